operand_extender: RTL and testbench

OPERAND_EXTENDER -- requirements
Module: operand_extender

---
 rtl/operand_extender.sv | 166 ++++++++++++++++
 tb/tb_operand_extender.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/operand_extender.sv
// -----------------------------------------------------------------------------
// operand_extender
//
// Extends an AB-bit immediate field to a DB-bit word and buffers the results
// in a 2-entry FIFO with valid/ready handshakes on both sides.
//
// Extension modes (mode):
//   2'b00  sign-extend   : {DB-AB copies of Addr[AB-1], Addr}
//   2'b01  zero-extend   : {DB-AB zeros, Addr}
//   2'b10  upper-place   : {Addr, DB-AB zeros}
//   2'b11  reserved      : result 0 with out_err = 1
//
// Parameters:
//   AB  width of the immediate field (default 11)
//   DB  width of the extended word   (default 16), AB <= DB
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    producer offers Addr/mode
//   in_ready    FIFO has room (registered state only)
//   Addr        immediate field
//   mode        extension mode
//   out_valid   Salida/out_err hold a valid result (FIFO not empty)
//   out_ready   consumer takes the head result
//   Salida      extended result, 0 when out_valid is low
//   out_err     result came from the reserved mode, 0 when out_valid is low
//   xfer_count  16-bit wrapping count of accepted inputs
//               (exists only when the EXT_CNT_EN macro is defined)
//
// Configuration macro: EXT_CNT_EN enables the xfer_count port and counter.
// -----------------------------------------------------------------------------
module operand_extender #(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AB-1:0] Addr,
  input  logic [1:0]    mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DB-1:0] Salida,
  output logic          out_err
`ifdef EXT_CNT_EN
  ,
  output logic [15:0]   xfer_count
`endif
);

  if (AB < 1 || AB > DB) begin : g_bad_width
    $error("operand_extender: AB must satisfy 1 <= AB <= DB");
  end

  localparam logic [1:0] MODE_SEXT  = 2'b00;
  localparam logic [1:0] MODE_ZEXT  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;

  // Extension of one immediate; the reserved mode yields zero.
  function automatic logic [DB-1:0] extend(input logic [AB-1:0] a,
                                           input logic [1:0]    m);
    logic signed [AB-1:0] a_s;
    logic signed [DB-1:0] sext;
    logic        [DB-1:0] zext;
    a_s  = a;
    sext = DB'(a_s);
    zext = DB'(a);
    case (m)
      MODE_SEXT:  extend = sext;
      MODE_ZEXT:  extend = zext;
      MODE_UPPER: extend = zext << (DB - AB);
      default:    extend = '0;
    endcase
  endfunction

  function automatic logic is_reserved(input logic [1:0] m);
    is_reserved = (m == 2'b11);
  endfunction

  // Control state
  logic [1:0] r_occ;
  logic       w_push;
  logic       w_pop;

  // Data state: head is the oldest entry, tail the second one
  logic [DB-1:0] r_head_p1;
  logic          r_head_err_p1;
  logic [DB-1:0] r_tail_p1;
  logic          r_tail_err_p1;

  logic [DB-1:0] w_ext_p0;
  logic          w_err_p0;
  logic          vld_p1;

  // ---- stage p0: combinational extension of the offered operand ----
  assign w_ext_p0 = extend(Addr, mode);
  assign w_err_p0 = is_reserved(mode);

  assign in_ready = (r_occ != 2'd2);
  assign vld_p1   = (r_occ != 2'd0);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = vld_p1 && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // ---- stage p1: FIFO storage ----
  // Data registers carry no reset; out_valid gating keeps stale contents
  // invisible. The head is only rewritten when it is consumed or empty, so
  // it is stable while the consumer stalls.
  always_ff @(posedge clk) begin
    case (r_occ)
      2'd0: begin
        if (w_push) begin
          r_head_p1     <= w_ext_p0;
          r_head_err_p1 <= w_err_p0;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          r_head_p1     <= w_ext_p0;
          r_head_err_p1 <= w_err_p0;
        end else if (w_push) begin
          r_tail_p1     <= w_ext_p0;
          r_tail_err_p1 <= w_err_p0;
        end
      end
      default: begin
        if (w_pop) begin
          r_head_p1     <= r_tail_p1;
          r_head_err_p1 <= r_tail_err_p1;
        end
      end
    endcase
  end

  assign out_valid = vld_p1;
  assign Salida    = vld_p1 ? r_head_p1 : '0;
  assign out_err   = vld_p1 ? r_head_err_p1 : 1'b0;

`ifdef EXT_CNT_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xfer_count <= 16'd0;
    end else if (w_push) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_operand_extender.sv
module tb_operand_extender;

  localparam int AB = 11;
  localparam int DB = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AB-1:0] Addr;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [DB-1:0] Salida;
  logic          out_err;
`ifdef EXT_CNT_EN
  logic [15:0]   xfer_count;
`endif

  int checks   = 0;
  int failures = 0;

  operand_extender #(.AB(AB), .DB(DB)) dut (
`ifdef EXT_CNT_EN
    .xfer_count (xfer_count),
`endif
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Addr       (Addr),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Salida     (Salida),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs: valid, data, err together
  task automatic check_out(input string tag, input logic v,
                           input logic [DB-1:0] d, input logic e);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(Salida),    32'(d));
    check({tag, ".err"},   32'(out_err),   32'(e));
  endtask

  task automatic offer(input logic v, input logic [AB-1:0] a,
                       input logic [1:0] m);
    in_valid = v;
    Addr     = a;
    mode     = m;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    Addr      = '0;
    mode      = 2'b00;
    out_ready = 1'b0;

    #1;
    check_out("reset", 1'b0, 16'h0000, 1'b0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
`ifdef EXT_CNT_EN
    check("reset.count", 32'(xfer_count), 32'd0);
`endif

    @(negedge clk);
    reset = 1'b0;

    // Sign-extend with the top field bit set, immediate first acceptance
    out_ready = 1'b1;
    offer(1'b1, 11'h400, 2'b00);
    @(negedge clk);
    offer(1'b0, 11'h000, 2'b00);
    check_out("sext400", 1'b1, 16'hFC00, 1'b0);
    @(negedge clk);
    check_out("drained1", 1'b0, 16'h0000, 1'b0);

    // Back-to-back zero-extend, upper-place, reserved
    offer(1'b1, 11'h400, 2'b01);
    @(negedge clk);
    check_out("zext400", 1'b1, 16'h0400, 1'b0);
    offer(1'b1, 11'h400, 2'b10);
    @(negedge clk);
    check_out("upper400", 1'b1, 16'h8000, 1'b0);
    offer(1'b1, 11'h400, 2'b11);
    @(negedge clk);
    check_out("reserved", 1'b1, 16'h0000, 1'b1);
    offer(1'b1, 11'h7FF, 2'b10);
    @(negedge clk);
    check_out("upper7FF", 1'b1, 16'hFFE0, 1'b0);
    offer(1'b0, 11'h000, 2'b00);
    @(negedge clk);
    check_out("drained2", 1'b0, 16'h0000, 1'b0);

    // Fill with consumer stalled, third offer held off
    out_ready = 1'b0;
    offer(1'b1, 11'h001, 2'b01);
    @(negedge clk);
    check("fill1.in_ready", 32'(in_ready), 32'd1);
    check_out("fill1", 1'b1, 16'h0001, 1'b0);
    offer(1'b1, 11'h002, 2'b01);
    @(negedge clk);
    check("fill2.in_ready", 32'(in_ready), 32'd0);
    offer(1'b1, 11'h003, 2'b01);
    @(negedge clk);
    check("full.in_ready", 32'(in_ready), 32'd0);
    check_out("full.stable", 1'b1, 16'h0001, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check_out("pop1", 1'b1, 16'h0002, 1'b0);
    check("pop1.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_out("pop2", 1'b1, 16'h0003, 1'b0);
    offer(1'b0, 11'h000, 2'b00);
    @(negedge clk);
    check_out("drained3", 1'b0, 16'h0000, 1'b0);

    // Same-cycle accept and consume at occupancy 1
    out_ready = 1'b0;
    offer(1'b1, 11'h100, 2'b01);
    @(negedge clk);
    check_out("occ1", 1'b1, 16'h0100, 1'b0);
    out_ready = 1'b1;
    offer(1'b1, 11'h7FF, 2'b00);
    @(negedge clk);
    check_out("swap", 1'b1, 16'hFFFF, 1'b0);
    check("swap.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    offer(1'b0, 11'h000, 2'b00);
    @(negedge clk);
    check_out("swap.hold", 1'b1, 16'hFFFF, 1'b0);
    out_ready = 1'b1;
    offer(1'b1, 11'h7FF, 2'b01);
    @(negedge clk);
    check_out("zext7FF", 1'b1, 16'h07FF, 1'b0);
    offer(1'b0, 11'h000, 2'b00);
    @(negedge clk);
    check_out("drained4", 1'b0, 16'h0000, 1'b0);

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    offer(1'b1, 11'h123, 2'b01);
    @(negedge clk);
    offer(1'b1, 11'h456, 2'b11);
    @(negedge clk);
    offer(1'b0, 11'h000, 2'b00);
    check("pre_rst.in_ready", 32'(in_ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 16'h0000, 1'b0);
    check("async_rst.in_ready", 32'(in_ready), 32'd1);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_out("post_rst", 1'b0, 16'h0000, 1'b0);
    offer(1'b1, 11'h00A, 2'b01);
    @(negedge clk);
    offer(1'b0, 11'h000, 2'b00);
    check_out("post_rst.first", 1'b1, 16'h000A, 1'b0);
    @(negedge clk);
    check_out("drained5", 1'b0, 16'h0000, 1'b0);

`ifdef EXT_CNT_EN
    // Counter wrap: 65535 accepts from reset, then one more
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("cnt.zero", 32'(xfer_count), 32'd0);
    out_ready = 1'b1;
    offer(1'b1, 11'h001, 2'b01);
    repeat (65535) @(negedge clk);
    offer(1'b0, 11'h000, 2'b00);
    check("cnt.max", 32'(xfer_count), 32'h0000FFFF);
    @(negedge clk);
    offer(1'b1, 11'h002, 2'b01);
    @(negedge clk);
    offer(1'b0, 11'h000, 2'b00);
    check("cnt.wrap", 32'(xfer_count), 32'h00000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
